// File: rtl/sram_ctrl_pkg.sv
// Shared widths and request record for the SRAM front ends.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_ADDR_W = 14;
   localparam int unsigned SRAM_DATA_W = 32;
   localparam int unsigned SRAM_BE_W   = SRAM_DATA_W / 8;

   typedef struct packed {
      logic                   rnw;
      logic [SRAM_ADDR_W-1:0] address;
      logic [SRAM_BE_W-1:0]   be;
      logic [SRAM_DATA_W-1:0] wdata;
   } sram_req_t;

   // Bits needed to hold a count from 0 to depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sram_req_resp_ctrl_if.sv
// Request and response handshake bundle between a requester and the SRAM front end.
interface sram_req_resp_ctrl_if #(
   parameter int unsigned address_width = 14,
   parameter int unsigned data_width    = 32
);
   localparam int unsigned BE_W = data_width / 8;

   logic                     req_valid;
   logic                     req_ack;
   logic                     req_read_not_write;
   logic [address_width-1:0] req_address;
   logic [BE_W-1:0]          req_byte_enable;
   logic [data_width-1:0]    req_write_data;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [data_width-1:0]    resp_data;

   modport master (
      output req_valid, req_read_not_write, req_address, req_byte_enable,
             req_write_data, resp_ready,
      input  req_ack, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_read_not_write, req_address, req_byte_enable,
             req_write_data, resp_ready,
      output req_ack, resp_valid, resp_data
   );
endinterface

// File: rtl/sram_resp_fifo.sv
// Synchronous response FIFO with pointer wrap at an arbitrary depth; caller never pushes when full.
module sram_resp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter  int unsigned depth = 4,
   parameter  int unsigned width = 32,
   localparam int unsigned CNT_W = cnt_width(depth)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] count_o,
   output logic [width-1:0] head_o
);
   localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;

   logic [width-1:0] mem_q [depth];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_req_resp_ctrl.sv
// Request/response front end for the single-port byte-write SRAM: registered strobes,
// one-cycle-late read capture and a credit-protected in-order response FIFO.
module sram_req_resp_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned resp_fifo_depth = 4,
   parameter int unsigned address_width   = SRAM_ADDR_W,
   parameter int unsigned data_width      = SRAM_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   sram_req_resp_ctrl_if.slave       bus,
   output logic                      sram_select,
   output logic                      sram_read_not_write,
   output logic [address_width-1:0]  sram_address,
   output logic [data_width/8-1:0]   sram_write_enable,
   output logic [data_width-1:0]     sram_write_data,
   input  logic [data_width-1:0]     sram_data_out
);
   localparam int unsigned CNT_W = cnt_width(resp_fifo_depth);

   sram_req_t        r_q, r_d;
   logic             r_valid_q, r_valid_d;
   logic             s_read_valid_q, s_read_valid_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   inflight_c;
   logic             accept_c;
   logic             pop_c;

   // Reads occupy a credit from acceptance until their response is popped.
   assign inflight_c = (CNT_W+1)'(r_valid_q && r_q.rnw)
                     + (CNT_W+1)'(s_read_valid_q)
                     + (CNT_W+1)'(fifo_count);

   assign bus.req_ack = !bus.req_read_not_write
                      || (inflight_c < (CNT_W+1)'(resp_fifo_depth));
   assign accept_c    = bus.req_valid && bus.req_ack;

   // Stage R holds the byte enables pre-masked so the write strobe is a plain flop.
   always_comb begin
      r_d            = r_q;
      r_d.be         = '0;
      r_valid_d      = accept_c;
      s_read_valid_d = r_valid_q && r_q.rnw;
      if (accept_c) begin
         r_d.rnw     = bus.req_read_not_write;
         r_d.address = bus.req_address;
         r_d.be      = bus.req_read_not_write ? '0 : bus.req_byte_enable;
         r_d.wdata   = bus.req_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_q            <= '0;
         r_valid_q      <= 1'b0;
         s_read_valid_q <= 1'b0;
      end else begin
         r_q            <= r_d;
         r_valid_q      <= r_valid_d;
         s_read_valid_q <= s_read_valid_d;
      end
   end

   assign sram_select         = r_valid_q;
   assign sram_read_not_write = r_q.rnw;
   assign sram_address        = r_q.address;
   assign sram_write_enable   = r_q.be;
   assign sram_write_data     = r_q.wdata;

   assign bus.resp_valid = (fifo_count != '0);
   assign pop_c          = bus.resp_valid && bus.resp_ready;

   sram_resp_fifo #(
      .depth (resp_fifo_depth),
      .width (data_width)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (s_read_valid_q),
      .push_data_i (sram_data_out),
      .pop_i       (pop_c),
      .count_o     (fifo_count),
      .head_o      (bus.resp_data)
   );

endmodule
